cc_regbank_mux: RTL

CC_REGBANK_MUX -- requirements
Module: cc_regbank_mux

---
 rtl/cc_regbank_pkg.sv | 30 +++
 rtl/cc_regbank_mux_if.sv | 36 +++
 rtl/cc_regbank_rdport.sv | 53 +++++
 rtl/cc_regbank_mux.sv | 92 +++++++++
 4 files changed

// File: rtl/cc_regbank_pkg.sv
// rtl/cc_regbank_pkg.sv - shared constants and helpers for the register bank
package cc_regbank_pkg;

  // Default bus and select widths and the number of implemented registers
  localparam int DEF_DATAWIDTH_BUS = 32;
  localparam int DEF_DATAWIDTH_SEL = 4;
  localparam int DEF_NUM_REGS      = 14;

  // Register index map
  localparam int G0    = 0;
  localparam int G1    = 1;
  localparam int G2    = 2;
  localparam int G3    = 3;
  localparam int G4    = 4;
  localparam int G5    = 5;
  localparam int G6    = 6;
  localparam int G7    = 7;
  localparam int PC    = 8;
  localparam int TEMP0 = 9;
  localparam int TEMP1 = 10;
  localparam int TEMP2 = 11;
  localparam int TEMP3 = 12;
  localparam int IR    = 13;

  // True when an index addresses an implemented register
  function automatic logic idx_in_range(input int idx, input int num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/cc_regbank_mux_if.sv
// rtl/cc_regbank_mux_if.sv - write/read bus bundle for the register bank
interface cc_regbank_mux_if
  import cc_regbank_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int DATAWIDTH_SEL = DEF_DATAWIDTH_SEL
) ();

  logic [DATAWIDTH_BUS-1:0] CC_REGBANK_C_Data_In;
  logic [DATAWIDTH_SEL-1:0] CC_REGBANK_C_Sel_In;
  logic                     CC_REGBANK_C_WrEn_In;
  logic [DATAWIDTH_SEL-1:0] CC_REGBANK_A_Sel_In;
  logic [DATAWIDTH_SEL-1:0] CC_REGBANK_B_Sel_In;
  logic                     CC_REGBANK_RdEn_In;
  logic [DATAWIDTH_BUS-1:0] CC_REGBANK_A_Data_Out;
  logic [DATAWIDTH_BUS-1:0] CC_REGBANK_B_Data_Out;
  logic                     CC_REGBANK_Valid_Out;
  logic                     CC_REGBANK_SelErr_Out;

  // Requester side: drives selects, write data and enables
  modport master (
    output CC_REGBANK_C_Data_In, CC_REGBANK_C_Sel_In, CC_REGBANK_C_WrEn_In,
    output CC_REGBANK_A_Sel_In, CC_REGBANK_B_Sel_In, CC_REGBANK_RdEn_In,
    input  CC_REGBANK_A_Data_Out, CC_REGBANK_B_Data_Out,
    input  CC_REGBANK_Valid_Out, CC_REGBANK_SelErr_Out
  );

  // Register bank side
  modport slave (
    input  CC_REGBANK_C_Data_In, CC_REGBANK_C_Sel_In, CC_REGBANK_C_WrEn_In,
    input  CC_REGBANK_A_Sel_In, CC_REGBANK_B_Sel_In, CC_REGBANK_RdEn_In,
    output CC_REGBANK_A_Data_Out, CC_REGBANK_B_Data_Out,
    output CC_REGBANK_Valid_Out, CC_REGBANK_SelErr_Out
  );

endinterface

// File: rtl/cc_regbank_rdport.sv
// rtl/cc_regbank_rdport.sv - one registered read port with write-through bypass
module cc_regbank_rdport
  import cc_regbank_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int DATAWIDTH_SEL = DEF_DATAWIDTH_SEL,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int ZERO_REG_EN   = 1
) (
  input  logic                                   clk_i,
  input  logic                                   resetn_i,
  input  logic                                   rd_en_i,
  input  logic [DATAWIDTH_SEL-1:0]               sel_i,
  input  logic                                   wr_ok_i,
  input  logic [DATAWIDTH_SEL-1:0]               wr_sel_i,
  input  logic [DATAWIDTH_BUS-1:0]               wr_data_i,
  input  logic [NUM_REGS-1:0][DATAWIDTH_BUS-1:0] regs_i,
  output logic [DATAWIDTH_BUS-1:0]               data_o,
  output logic                                   oor_o
);

  logic                     in_range;
  logic [DATAWIDTH_BUS-1:0] data_d;
  logic [DATAWIDTH_BUS-1:0] data_q;

  // Select the read value: zero for g0 and unimplemented indices, bypass a same-cycle write
  always_comb begin
    in_range = idx_in_range(int'(sel_i), NUM_REGS);
    data_d   = '0;
    if (in_range && !(ZERO_REG_EN != 0 && sel_i == '0)) begin
      if (wr_ok_i && wr_sel_i == sel_i) begin
        data_d = wr_data_i;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (sel_i == DATAWIDTH_SEL'(i)) data_d = regs_i[i];
        end
      end
    end
  end

  // Output register loads only on a read request, otherwise holds
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      data_q <= '0;
    end else if (rd_en_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign oor_o  = !in_range;

endmodule

// File: rtl/cc_regbank_mux.sv
// rtl/cc_regbank_mux.sv - register bank with one write port and two read ports
module cc_regbank_mux
  import cc_regbank_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int DATAWIDTH_SEL = DEF_DATAWIDTH_SEL,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int ZERO_REG_EN   = 1
) (
  input  logic             CC_REGBANK_CLOCK_50,
  input  logic             CC_REGBANK_RESET_InLow,
  cc_regbank_mux_if.slave  bus
);

  logic [NUM_REGS-1:0][DATAWIDTH_BUS-1:0] regs_q;
  logic                                   c_in_range;
  logic                                   wr_ok;
  logic                                   a_oor;
  logic                                   b_oor;
  logic                                   valid_q;
  logic                                   sel_err_q;
  logic                                   sel_err_d;

  // A write commits only to an implemented, writable register
  assign c_in_range = idx_in_range(int'(bus.CC_REGBANK_C_Sel_In), NUM_REGS);
  assign wr_ok      = bus.CC_REGBANK_C_WrEn_In && c_in_range &&
                      !(ZERO_REG_EN != 0 && bus.CC_REGBANK_C_Sel_In == '0);
  assign sel_err_d  = (bus.CC_REGBANK_RdEn_In && (a_oor || b_oor)) ||
                      (bus.CC_REGBANK_C_WrEn_In && !c_in_range);

  // Register array update
  always_ff @(posedge CC_REGBANK_CLOCK_50) begin
    if (!CC_REGBANK_RESET_InLow) begin
      regs_q <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.CC_REGBANK_C_Sel_In == DATAWIDTH_SEL'(i)) regs_q[i] <= bus.CC_REGBANK_C_Data_In;
      end
    end
  end

  // Valid and select-error pulses, one cycle after the qualifying edge
  always_ff @(posedge CC_REGBANK_CLOCK_50) begin
    if (!CC_REGBANK_RESET_InLow) begin
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= bus.CC_REGBANK_RdEn_In;
      sel_err_q <= sel_err_d;
    end
  end

  cc_regbank_rdport #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .DATAWIDTH_SEL (DATAWIDTH_SEL),
    .NUM_REGS      (NUM_REGS),
    .ZERO_REG_EN   (ZERO_REG_EN)
  ) u_rd_a (
    .clk_i     (CC_REGBANK_CLOCK_50),
    .resetn_i  (CC_REGBANK_RESET_InLow),
    .rd_en_i   (bus.CC_REGBANK_RdEn_In),
    .sel_i     (bus.CC_REGBANK_A_Sel_In),
    .wr_ok_i   (wr_ok),
    .wr_sel_i  (bus.CC_REGBANK_C_Sel_In),
    .wr_data_i (bus.CC_REGBANK_C_Data_In),
    .regs_i    (regs_q),
    .data_o    (bus.CC_REGBANK_A_Data_Out),
    .oor_o     (a_oor)
  );

  cc_regbank_rdport #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .DATAWIDTH_SEL (DATAWIDTH_SEL),
    .NUM_REGS      (NUM_REGS),
    .ZERO_REG_EN   (ZERO_REG_EN)
  ) u_rd_b (
    .clk_i     (CC_REGBANK_CLOCK_50),
    .resetn_i  (CC_REGBANK_RESET_InLow),
    .rd_en_i   (bus.CC_REGBANK_RdEn_In),
    .sel_i     (bus.CC_REGBANK_B_Sel_In),
    .wr_ok_i   (wr_ok),
    .wr_sel_i  (bus.CC_REGBANK_C_Sel_In),
    .wr_data_i (bus.CC_REGBANK_C_Data_In),
    .regs_i    (regs_q),
    .data_o    (bus.CC_REGBANK_B_Data_Out),
    .oor_o     (b_oor)
  );

  assign bus.CC_REGBANK_Valid_Out  = valid_q;
  assign bus.CC_REGBANK_SelErr_Out = sel_err_q;

endmodule
